// File: rtl/approx_err_stats.sv
// rtl/approx_err_stats.sv - error-distance statistics (sum, max, count) for an approximate signed multiplier
module approx_err_stats #(
   parameter int W     = 16,
   parameter int CNT_W = 20,
   parameter int ACC_W = 52
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [CNT_W-1:0]   n_samples,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       a,
   input  logic [W-1:0]       b,
   input  logic [2*W-1:0]     product,
   output logic               busy,
   output logic               done,
   output logic [ACC_W-1:0]   sum_ed,
   output logic [2*W-1:0]     max_ed,
   output logic [CNT_W-1:0]   err_cnt,
   output logic [CNT_W-1:0]   sample_cnt
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   n_q, n_d;
   logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
   logic [1:0]         drain_q, drain_d;
   logic               done_q, done_d;
   logic               in_ready_q, in_ready_d;
   logic               busy_q, busy_d;
   logic               clear;
   logic               transfer;

   logic               s1_v_q, s1_v_d;
   logic [2*W:0]       exact_q, exact_d;
   logic [2*W:0]       approx_q, approx_d;
   logic               s2_v_q, s2_v_d;
   logic [2*W-1:0]     ed_q, ed_d;
   logic [2*W-1:0]     mult;
   logic [2*W:0]       diff;
   logic [2*W:0]       diff_abs;

   logic [ACC_W-1:0]   sum_q, sum_d;
   logic [2*W-1:0]     max_q, max_d;
   logic [CNT_W-1:0]   err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   assign transfer = in_valid & in_ready_q;

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      acc_cnt_d = acc_cnt_q;
      drain_d   = drain_q;
      done_d    = 1'b0;
      clear     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               clear     = 1'b1;
               n_d       = n_samples;
               acc_cnt_d = '0;
               if (n_samples == '0) done_d = 1'b1;
               else                 state_d = RUN;
            end
         end
         RUN: begin
            if (transfer) begin
               acc_cnt_d = acc_cnt_q + 1'b1;
               if (acc_cnt_d == n_q) begin
                  state_d = DRAIN;
                  drain_d = 2'd0;
               end
            end
         end
         DRAIN: begin
            // Three edges in DRAIN let the last beat reach the accumulator.
            if (drain_q == 2'd2) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == RUN);
      busy_d     = (state_d != IDLE);
   end

   always_comb begin
      mult     = $signed(a) * $signed(b);
      exact_d  = {mult[2*W-1], mult};
      approx_d = {product[2*W-1], product};
      s1_v_d   = transfer;
      diff     = approx_q - exact_q;
      diff_abs = diff[2*W] ? (~diff + 1'b1) : diff;
      // |approx - exact| never exceeds 3*2^(2W-2), so the top bit is always zero.
      ed_d     = diff_abs[2*W-1:0];
      s2_v_d   = s1_v_q;

      sum_d = sum_q;
      max_d = max_q;
      err_d = err_q;
      cnt_d = cnt_q;
      if (clear) begin
         sum_d = '0;
         max_d = '0;
         err_d = '0;
         cnt_d = '0;
      end else if (s2_v_q) begin
         sum_d = sum_q + ACC_W'(ed_q);
         cnt_d = cnt_q + 1'b1;
         if (ed_q != '0)   err_d = err_q + 1'b1;
         if (ed_q > max_q) max_d = ed_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         n_q        <= '0;
         acc_cnt_q  <= '0;
         drain_q    <= '0;
         done_q     <= 1'b0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         s1_v_q     <= 1'b0;
         exact_q    <= '0;
         approx_q   <= '0;
         s2_v_q     <= 1'b0;
         ed_q       <= '0;
         sum_q      <= '0;
         max_q      <= '0;
         err_q      <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         acc_cnt_q  <= acc_cnt_d;
         drain_q    <= drain_d;
         done_q     <= done_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         s1_v_q     <= s1_v_d;
         exact_q    <= exact_d;
         approx_q   <= approx_d;
         s2_v_q     <= s2_v_d;
         ed_q       <= ed_d;
         sum_q      <= sum_d;
         max_q      <= max_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign sum_ed     = sum_q;
   assign max_ed     = max_q;
   assign err_cnt    = err_q;
   assign sample_cnt = cnt_q;
endmodule

// File: doc/approx_err_stats.md
# approx_err_stats

Downstream error-metric accumulator for the 16x16 signed approximate multiplier `top`. It takes operand pairs `a`/`b` and the approximate `product` that `top` returned for them, and forms the exact signed product internally. Over a window of `n_samples` accepted beats it accumulates the sum of absolute error distances, the maximum error distance, and the count of erroneous results. It replaces offline post-processing of dumped result files with an on-chip characterisation path (e.g. MED = `sum_ed / sample_cnt`, computed by software).

## Interface

Parameters:
- `W`, 16, operand width (signed); the product is 2W bits.
- `CNT_W`, 20, sample-counter width; supports up to 2^20-1 samples.
- `ACC_W`, 52, `sum_ed` width; must be at least 2W+CNT_W so the sum cannot overflow.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: pulse; begins a measurement window. Honoured only when idle.
- `n_samples`, in, CNT_W: window length, latched on an accepted `start`.
- `in_valid`, in, 1: the `a`/`b`/`product` beat is valid.
- `in_ready`, out, 1: block accepts a beat. A beat transfers when `in_valid & in_ready`.
- `a`, `b`, in, W: signed operands.
- `product`, in, 2W: signed approximate product from `top`.
- `busy`, out, 1: window in progress (RUN or DRAIN).
- `done`, out, 1: one-cycle pulse; results are final.
- `sum_ed`, out, ACC_W: Σ|exact − approx|.
- `max_ed`, out, 2W: max |exact − approx|, unsigned.
- `err_cnt`, out, CNT_W: number of beats with |ED| ≠ 0.
- `sample_cnt`, out, CNT_W: number of beats accumulated.

## Operation

- FSM states are IDLE, RUN and DRAIN.
  - IDLE: `in_ready`=0 and `busy`=0.
    - On `start`: clear all four result registers, latch `n_samples` into N, and clear the accept counter.
    - If N=0: stay in IDLE and pulse `done` on the next edge.
    - Otherwise: go to RUN.
  - RUN: `in_ready`=1. Each transfer increments the accept counter. On the transfer that makes the count equal N, go to DRAIN.
  - DRAIN: `in_ready`=0. Hold for 3 edges while the pipeline flushes, then go to IDLE and pulse `done`.
- `start` is ignored while `busy`. `in_valid` is ignored outside RUN; beats beyond N are never taken.
- Datapath is a 3-stage pipeline with a valid bit per stage:
  - S1 registers `exact = $signed(a)*$signed(b)`, sign-extended to 2W+1 bits, together with `product` sign-extended to 2W+1 bits.
  - S2 registers `ed = |approx − exact|`, computed in 2W+1 bits signed. The result always fits in 2W bits unsigned; the maximum is 3·2^30 for W=16.
  - S3 (the accumulator) applies, when its input is valid:
    - `sum_ed += ed`
    - `sample_cnt += 1`
    - `err_cnt += (ed≠0)`
    - `max_ed = max(max_ed, ed)`
- Results hold their values after `done` until the next accepted `start` or reset.
- Reset (`rst`=1 at an edge) applies at any time, including mid-window or mid-drain:
  - State goes to IDLE and all pipeline valids clear.
  - All outputs become 0: `in_ready`, `busy`, `done`, `sum_ed`, `max_ed`, `err_cnt`, `sample_cnt`.
  - Reset takes priority over `start`.

## Timing

- `start` sampled at edge 0: `busy`=1 and `in_ready`=1 from edge 0.
- With `in_valid` held high, beats transfer at edges 1..N.
- Beat accepted at edge k: S1 at k+1, S2 at k+2, accumulated at k+3.
- After the last transfer at edge N, `in_ready`=0 from edge N.
  - At edge N+3: results are final, `done`=1 for one cycle, `busy`=0.
- Bubbles (`in_valid`=0) in RUN add no cycles beyond the stall itself. DRAIN is always exactly 3 cycles.
- N=0: `done`=1 in the cycle after edge 0; `busy` stays 0.
- A new `start` in the same cycle `done` is high is accepted, since the FSM is already in IDLE.

## Test plan

- Reset mid-window: N=10, assert `rst` after 4 beats for 2 cycles.
  - Required: all outputs 0 and state IDLE.
  - A following `start` with N=2 completes normally, with `sample_cnt`=2.
- Exact match: N=4, every `product`=a·b, start at edge 0, continuous valid.
  - Required: `done` at edge 7; `sum_ed`=0, `max_ed`=0, `err_cnt`=0, `sample_cnt`=4.
- Known errors: N=3 with beats (3,5,14), (−2,7,−10), (−32768,−32768,0).
  - Required: `sum_ed`=2^30+5, `max_ed`=2^30, `err_cnt`=3.
- Extreme width: N=1 with a=b=−32768 and `product`=32'h8000_0000.
  - Required: `max_ed`=`sum_ed`=32'hC000_0000 and `err_cnt`=1.
- Handshake:
  - N=3 with `in_valid` pattern 1,0,1,0,1,1,1: exactly 3 beats taken, `in_ready` drops after the 3rd, and `done` comes 3 edges after it.
  - `start` pulsed during RUN changes nothing.
- N=0: `done` pulses one cycle after `start`, all results 0, and `in_ready` never rises.
